// File: rtl/uart_cmd_responder.sv
// Command responder: parses A5-framed 5-byte commands from the RX byte stream, performs one
// register read or write, and returns a 5-byte 5A-framed response on the TX byte stream.
module uart_cmd_responder #(
  parameter int unsigned REG_NUM        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  input  logic       rx_err,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_data_ready,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] IdleMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StHunt, StCmd, StAddr, StData, StCsum, StExec, StRdWait, StResp
  } state_e;

  state_e          state_q;
  logic [7:0]      cmd_q, addr_q, data_q, status_q, rdata_q;
  logic            perr_q;
  logic [2:0]      idx_q;
  logic [CntW-1:0] idle_q;
  logic [7:0]      tx_data_q, reg_addr_q, reg_wdata_q;
  logic            tx_valid_q, reg_wr_q, reg_rd_q;

  logic       in_frame, accept, tx_xfer;
  logic [7:0] status_c;

  assign in_frame      = (state_q == StCmd) || (state_q == StAddr) ||
                         (state_q == StData) || (state_q == StCsum);
  assign rx_data_ready = rst_n && (in_frame || (state_q == StHunt));
  assign accept        = rx_data_valid && rx_data_ready;
  assign tx_xfer       = tx_valid_q && tx_data_ready;
  assign busy          = (state_q != StHunt);

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign reg_wr        = reg_wr_q;
  assign reg_rd        = reg_rd_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;

  // Status is resolved while the checksum byte is on the bus so strobes can be registered
  // into the EXEC cycle.
  always_comb begin
    status_c = 8'h00;
    if (perr_q || rx_err) begin
      status_c = 8'h03;
    end else if (rx_data != (cmd_q ^ addr_q ^ data_q)) begin
      status_c = 8'h01;
    end else if ((cmd_q != 8'h01) && (cmd_q != 8'h02)) begin
      status_c = 8'h02;
    end else if (32'(addr_q) >= REG_NUM) begin
      status_c = 8'h04;
    end
  end

  function automatic logic [7:0] resp_byte(input logic [2:0] idx);
    unique case (idx)
      3'd0:    resp_byte = 8'h5A;
      3'd1:    resp_byte = status_q;
      3'd2:    resp_byte = addr_q;
      3'd3:    resp_byte = rdata_q;
      default: resp_byte = status_q ^ addr_q ^ rdata_q;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      status_q    <= 8'h00;
      rdata_q     <= 8'h00;
      perr_q      <= 1'b0;
      idx_q       <= 3'd0;
      idle_q      <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
    end else begin
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (accept && (rx_data == 8'hA5) && !rx_err) begin
            state_q <= StCmd;
            perr_q  <= 1'b0;
            idle_q  <= '0;
          end
        end
        StCmd: if (accept) begin
          cmd_q   <= rx_data;
          state_q <= StAddr;
        end
        StAddr: if (accept) begin
          addr_q  <= rx_data;
          state_q <= StData;
        end
        StData: if (accept) begin
          data_q  <= rx_data;
          state_q <= StCsum;
        end
        StCsum: if (accept) begin
          status_q <= status_c;
          rdata_q  <= 8'h00;
          state_q  <= StExec;
          if (status_c == 8'h00) begin
            reg_addr_q <= addr_q;
            if (cmd_q == 8'h01) begin
              reg_wr_q    <= 1'b1;
              reg_wdata_q <= data_q;
              rdata_q     <= data_q;
            end else begin
              reg_rd_q <= 1'b1;
            end
          end
        end
        StExec: begin
          if (reg_rd_q) begin
            state_q <= StRdWait;
          end else begin
            state_q    <= StResp;
            tx_data_q  <= resp_byte(3'd0);
            tx_valid_q <= 1'b1;
            idx_q      <= 3'd0;
          end
        end
        StRdWait: begin
          rdata_q    <= reg_rdata;
          state_q    <= StResp;
          tx_data_q  <= resp_byte(3'd0);
          tx_valid_q <= 1'b1;
          idx_q      <= 3'd0;
        end
        StResp: begin
          if (tx_xfer) begin
            if (idx_q == 3'd4) begin
              tx_valid_q <= 1'b0;
              state_q    <= StHunt;
            end else begin
              idx_q     <= idx_q + 3'd1;
              tx_data_q <= resp_byte(idx_q + 3'd1);
            end
          end
        end
        default: state_q <= StHunt;
      endcase

      // Inter-byte idle watchdog; an accepted byte always wins over an expiring count.
      if (in_frame) begin
        if (accept) begin
          idle_q <= '0;
          perr_q <= perr_q | rx_err;
        end else if (idle_q == IdleMax) begin
          state_q <= StHunt;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

endmodule
